// File: rtl/stall_bus_source_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stall_bus_source_if : upstream byte stream + stall-capable bus signals    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface stall_bus_source_if #(
  parameter int NUM    = 4,
  parameter int WIDTH  = 8,
  parameter int DROP_W = 8
);
  localparam int CNT_W = $clog2(NUM + 1);

  logic [WIDTH-1:0]  IN_data;
  logic              IN_valid;
  logic              IN_ready;
  logic              IN_flush;
  logic              IN_stall;
  logic [WIDTH-1:0]  OUT_data;
  logic              OUT_valid;
  logic [CNT_W-1:0]  OUT_count;
  logic [DROP_W-1:0] OUT_dropCnt;

  // master is the source block itself; slave is the producer/consumer side
  modport master (
    input  IN_data, IN_valid, IN_flush, IN_stall,
    output IN_ready, OUT_data, OUT_valid, OUT_count, OUT_dropCnt
  );

  modport slave (
    output IN_data, IN_valid, IN_flush, IN_stall,
    input  IN_ready, OUT_data, OUT_valid, OUT_count, OUT_dropCnt
  );
endinterface
`default_nettype wire

// File: rtl/stall_bus_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stall_bus_source : FIFO-buffered byte source with stall-holding output    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module stall_bus_source #(
  parameter int NUM    = 4,
  parameter int WIDTH  = 8,
  parameter int DROP_W = 8
) (
  input wire                  clk,
  input wire                  rst_n,
  stall_bus_source_if.master  bus
);
  localparam int PTR_W = $clog2(NUM);
  localparam int CNT_W = $clog2(NUM + 1);
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(NUM);

  logic [WIDTH-1:0]  mem_q [NUM];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic w_in_ready;
  logic w_accept;
  logic w_push;
  logic w_drop;
  logic w_adv;
  logic w_pop;

  // Full/empty come from the count register; pointers alone cannot tell them apart.
  assign w_in_ready = (count_q < C_FULL_CNT) && !bus.IN_flush;
  assign w_accept   = bus.IN_valid && w_in_ready;
  assign w_push     = w_accept && (|bus.IN_data);
  assign w_drop     = w_accept && !(|bus.IN_data);
  assign w_adv      = !out_valid_q || !bus.IN_stall;
  assign w_pop      = w_adv && (count_q != '0) && !bus.IN_flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    drop_cnt_d  = drop_cnt_q;

    if (w_drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    if (bus.IN_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        out_data_d  = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
      end else if (w_adv) begin
        out_data_d  = '0;
        out_valid_d = 1'b0;
      end
      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage is intentionally left unreset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.IN_data;
    end
  end

  assign bus.IN_ready    = w_in_ready;
  assign bus.OUT_data    = out_data_q;
  assign bus.OUT_valid   = out_valid_q;
  assign bus.OUT_count   = count_q;
  assign bus.OUT_dropCnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stall_bus_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stall_bus_source : directed self-checking bench for stall_bus_source   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_stall_bus_source;
  localparam int NUM    = 4;
  localparam int WIDTH  = 8;
  localparam int DROP_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic seen_valid;

  stall_bus_source_if #(.NUM(NUM), .WIDTH(WIDTH), .DROP_W(DROP_W)) bus ();

  stall_bus_source #(.NUM(NUM), .WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    assert (bus.OUT_valid == (|bus.OUT_data))
      else check("invariant", {31'd0, bus.OUT_valid}, {31'd0, |bus.OUT_data});
  end

  initial begin
    rst_n        = 1'b0;
    bus.IN_data  = '0;
    bus.IN_valid = 1'b0;
    bus.IN_flush = 1'b0;
    bus.IN_stall = 1'b0;
    #12;
    check("rst_data",  bus.OUT_data, 0);
    check("rst_valid", bus.OUT_valid, 0);
    check("rst_count", bus.OUT_count, 0);
    check("rst_drop",  bus.OUT_dropCnt, 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", bus.IN_ready, 1);
    step();

    // Three back-to-back bytes, no stall: two-cycle latency, count peaks at 1
    bus.IN_valid = 1'b1; bus.IN_data = 8'h11; step();
    check("t1_d0", bus.OUT_data, 8'h00); check("t1_c0", bus.OUT_count, 1);
    bus.IN_data = 8'h22; step();
    check("t1_d1", bus.OUT_data, 8'h11); check("t1_c1", bus.OUT_count, 1);
    bus.IN_data = 8'h33; step();
    check("t1_d2", bus.OUT_data, 8'h22); check("t1_c2", bus.OUT_count, 1);
    bus.IN_valid = 1'b0; step();
    check("t1_d3", bus.OUT_data, 8'h33); check("t1_c3", bus.OUT_count, 0);
    step();
    check("t1_d4", bus.OUT_data, 8'h00); check("t1_v4", bus.OUT_valid, 0);

    // Stall with full FIFO, then drain in order
    bus.IN_stall = 1'b1;
    bus.IN_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.IN_data = 8'hA0 + 8'(i);
      step();
    end
    check("t2_hold",   bus.OUT_data, 8'hA1);
    check("t2_full",   bus.OUT_count, 4);
    check("t2_nrdy",   bus.IN_ready, 0);
    bus.IN_data = 8'hA6; step();
    check("t2_hold2",  bus.OUT_data, 8'hA1);
    check("t2_nrdy2",  bus.IN_ready, 0);
    check("t2_full2",  bus.OUT_count, 4);
    bus.IN_stall = 1'b0; step();
    check("t2_a2",     bus.OUT_data, 8'hA2);
    check("t2_c3",     bus.OUT_count, 3);
    check("t2_rdy",    bus.IN_ready, 1);
    step();
    check("t2_a3",     bus.OUT_data, 8'hA3);
    check("t2_c3b",    bus.OUT_count, 3);
    bus.IN_valid = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      step();
      check("t2_drain", bus.OUT_data, 8'hA0 + 8'(i));
    end
    step();
    check("t2_idle",   bus.OUT_data, 8'h00);
    check("t2_empty",  bus.OUT_count, 0);

    // Zero bytes are dropped and counted
    bus.IN_valid = 1'b1; bus.IN_data = 8'h05; step();
    check("t3_d0", bus.OUT_data, 8'h00);
    bus.IN_data = 8'h00; step();
    check("t3_d1", bus.OUT_data, 8'h05);
    step();
    check("t3_d2", bus.OUT_data, 8'h00);
    bus.IN_data = 8'h07; step();
    check("t3_d3", bus.OUT_data, 8'h00);
    bus.IN_valid = 1'b0; step();
    check("t3_d4", bus.OUT_data, 8'h07);
    step();
    check("t3_d5", bus.OUT_data, 8'h00);
    check("t3_drop", bus.OUT_dropCnt, 2);

    // Flush with a valid byte present: nothing accepted, dropCnt kept
    bus.IN_stall = 1'b1;
    bus.IN_valid = 1'b1;
    bus.IN_data  = 8'h31; step();
    bus.IN_data  = 8'h32; step();
    bus.IN_data  = 8'h33; step();
    bus.IN_data  = 8'h34; step();
    check("t5_hold",  bus.OUT_data, 8'h31);
    check("t5_cnt",   bus.OUT_count, 3);
    bus.IN_flush = 1'b1;
    bus.IN_data  = 8'h99;
    #1;
    check("t5_nrdy",  bus.IN_ready, 0);
    step();
    check("t5_data",  bus.OUT_data, 8'h00);
    check("t5_valid", bus.OUT_valid, 0);
    check("t5_cnt0",  bus.OUT_count, 0);
    check("t5_drop",  bus.OUT_dropCnt, 2);
    bus.IN_flush = 1'b0;
    bus.IN_valid = 1'b0;
    bus.IN_stall = 1'b0;
    step(); step();
    check("t5_gone",  bus.OUT_data, 8'h00);
    check("t5_cnt1",  bus.OUT_count, 0);

    // 300 zero bytes: counter saturates, bus stays idle
    seen_valid   = 1'b0;
    bus.IN_valid = 1'b1;
    bus.IN_data  = 8'h00;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.OUT_valid) seen_valid = 1'b1;
      if (i == 251) check("t4_254", bus.OUT_dropCnt, 254);
      if (i == 252) check("t4_255", bus.OUT_dropCnt, 255);
    end
    bus.IN_valid = 1'b0;
    step();
    check("t4_sat",    bus.OUT_dropCnt, 255);
    check("t4_novld",  seen_valid, 0);

    // Asynchronous reset mid-stream
    bus.IN_valid = 1'b1; bus.IN_data = 8'h42; step();
    bus.IN_data  = 8'h43; step();
    bus.IN_stall = 1'b1; bus.IN_data = 8'h44; step();
    bus.IN_valid = 1'b0;
    check("t6_pre_d", bus.OUT_data, 8'h42);
    check("t6_pre_c", bus.OUT_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_d", bus.OUT_data, 8'h00);
    check("t6_rst_v", bus.OUT_valid, 0);
    check("t6_rst_c", bus.OUT_count, 0);
    check("t6_rst_dc", bus.OUT_dropCnt, 0);
    #1 rst_n = 1'b1;
    bus.IN_stall = 1'b0;
    step();
    bus.IN_valid = 1'b1; bus.IN_data = 8'h10; step();
    bus.IN_valid = 1'b0; step();
    check("t6_new",   bus.OUT_data, 8'h10);
    step();
    check("t6_idle",  bus.OUT_data, 8'h00);
    check("t6_cnt",   bus.OUT_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
